// File: rtl/add16_err_monitor.sv
// Error-characterisation wrapper around an external approximate adder: registers
// operands for the adder, compares its result with the exact sum and accumulates statistics.
module add16_err_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 32,
    parameter int ACC_W = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic [WIDTH-1:0]   dut_a,
    output logic [WIDTH-1:0]   dut_b,
    input  logic [WIDTH:0]     dut_o,
    input  logic               clear,
    output logic               busy,
    output logic [CNT_W-1:0]   stat_count,
    output logic [ACC_W-1:0]   stat_err_sum,
    output logic [WIDTH:0]     stat_wce,
    output logic [CNT_W-1:0]   stat_err_cnt
);

    logic               r_run;
    logic               r_s1_v;
    logic               r_s2_v;
    logic [WIDTH-1:0]   r_dut_a;
    logic [WIDTH-1:0]   r_dut_b;
    logic [WIDTH:0]     r_exact;
    logic [WIDTH:0]     r_err;
    logic [CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_err_sum;
    logic [WIDTH:0]     r_wce;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_fire;
    logic [CNT_W:0]     w_pending;
    logic [CNT_W:0]     w_limit;
    logic [WIDTH:0]     w_err;
    logic [ACC_W:0]     w_sum_ext;

    // Samples already in flight are reserved against the limit so count never wraps.
    assign w_pending = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_v} + {{CNT_W{1'b0}}, r_s2_v};
    assign w_limit   = {1'b0, {CNT_W{1'b1}}};
    assign in_ready  = r_run & ~clear & (w_pending < w_limit);
    assign w_fire    = in_valid & in_ready;

    assign w_err     = (r_exact >= dut_o) ? (r_exact - dut_o) : (dut_o - r_exact);
    assign w_sum_ext = {1'b0, r_err_sum} + {{(ACC_W-WIDTH){1'b0}}, r_err};

    // r_run keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run   <= 1'b0;
            r_dut_a <= '0;
            r_dut_b <= '0;
            r_exact <= '0;
            r_s1_v  <= 1'b0;
        end else begin
            r_run  <= 1'b1;
            r_s1_v <= w_fire & ~clear;
            if (w_fire) begin
                r_dut_a <= in_a;
                r_dut_b <= in_b;
                r_exact <= {1'b0, in_a} + {1'b0, in_b};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err  <= '0;
            r_s2_v <= 1'b0;
        end else begin
            r_err  <= w_err;
            r_s2_v <= r_s1_v & ~clear;
        end
    end

    // Statistics; clear wins over an update landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_err_sum <= '0;
            r_wce     <= '0;
            r_err_cnt <= '0;
        end else if (clear) begin
            r_count   <= '0;
            r_err_sum <= '0;
            r_wce     <= '0;
            r_err_cnt <= '0;
        end else if (r_s2_v) begin
            r_count   <= r_count + 1'b1;
            r_err_sum <= w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
            if (r_err != '0) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            if (r_err > r_wce) begin
                r_wce <= r_err;
            end
        end
    end

    assign dut_a        = r_dut_a;
    assign dut_b        = r_dut_b;
    assign busy         = r_s1_v | r_s2_v;
    assign stat_count   = r_count;
    assign stat_err_sum = r_err_sum;
    assign stat_wce     = r_wce;
    assign stat_err_cnt = r_err_cnt;

endmodule
